// File: rtl/ex_pkg.sv
// Shared types for the execute stage: ALU op codes, forward-select encodings
// and divider FSM states.
package ex_pkg;

    typedef enum logic [4:0] {
        ALU_ADD      = 5'd0,
        ALU_SUB      = 5'd1,
        ALU_AND      = 5'd2,
        ALU_OR       = 5'd3,
        ALU_XOR      = 5'd4,
        ALU_SLL      = 5'd5,
        ALU_SRL      = 5'd6,
        ALU_SRA      = 5'd7,
        ALU_SLT      = 5'd8,
        ALU_SLTU     = 5'd9,
        ALU_LUI_PASS = 5'd10,
        ALU_MUL      = 5'd11,
        ALU_DIV      = 5'd12,
        ALU_DIVU     = 5'd13,
        ALU_REM      = 5'd14,
        ALU_REMU     = 5'd15
    } alu_op_e;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_MEMWB   = 2'b01;
    localparam logic [1:0] FWD_EXMEM   = 2'b10;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_e;

    function automatic logic is_div_op(alu_op_e op);
        return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs, forwarding/hazard controls and EX/MEM outputs of the execute stage.
interface ex_stage_if import ex_pkg::*; #(parameter int XLEN = 32);

    logic            id_ex_valid;
    alu_op_e         id_ex_alu_op;
    logic [XLEN-1:0] id_ex_rs1_data;
    logic [XLEN-1:0] id_ex_rs2_data;
    logic [XLEN-1:0] id_ex_imm;
    logic            id_ex_use_imm;
    logic [4:0]      id_ex_rd;
    logic            id_ex_reg_write;
    logic            id_ex_mem_read;
    logic            id_ex_mem_write;
    logic [1:0]      forwardA;
    logic [1:0]      forwardB;
    logic [XLEN-1:0] ex_mem_fwd_data;
    logic [XLEN-1:0] mem_wb_fwd_data;
    logic            mem_stall;
    logic            flush;

    logic            ex_busy;
    logic            ex_mem_valid;
    logic [XLEN-1:0] ex_mem_result;
    logic [XLEN-1:0] ex_mem_store_data;
    logic [4:0]      ex_mem_rd;
    logic            ex_mem_reg_write;
    logic            ex_mem_mem_read;
    logic            ex_mem_mem_write;

    modport slave (
        input  id_ex_valid, id_ex_alu_op, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm,
               id_ex_use_imm, id_ex_rd, id_ex_reg_write, id_ex_mem_read, id_ex_mem_write,
               forwardA, forwardB, ex_mem_fwd_data, mem_wb_fwd_data, mem_stall, flush,
        output ex_busy, ex_mem_valid, ex_mem_result, ex_mem_store_data, ex_mem_rd,
               ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write
    );

    modport master (
        output id_ex_valid, id_ex_alu_op, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm,
               id_ex_use_imm, id_ex_rd, id_ex_reg_write, id_ex_mem_read, id_ex_mem_write,
               forwardA, forwardB, ex_mem_fwd_data, mem_wb_fwd_data, mem_stall, flush,
        input  ex_busy, ex_mem_valid, ex_mem_result, ex_mem_store_data, ex_mem_rd,
               ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write
    );

endinterface

// File: rtl/ex_stage_iter_divider.sv
// Radix-2 restoring divider with IDLE/BUSY/DONE handshake; only built when
// EX_STAGE_DIV_EN is defined.
`ifdef EX_STAGE_DIV_EN
module iter_divider import ex_pkg::*; #(
    parameter int XLEN       = 32,
    parameter int DIV_CYCLES = XLEN   // one quotient bit per iteration, so must equal XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic            hold_i,
    input  logic            signed_i,
    input  logic            rem_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(DIV_CYCLES);

    div_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, a_q, a_d;
    logic            qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d, remop_q, remop_d;
    logic            a_neg, b_neg;
    logic [XLEN:0]   diff;

    assign a_neg = signed_i & a_i[XLEN-1];
    assign b_neg = signed_i & b_i[XLEN-1];
    assign diff  = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        a_d     = a_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        remop_d = remop_q;
        unique case (state_q)
            IDLE: if (start_i) begin
                state_d = BUSY;
                cnt_d   = '0;
                rem_d   = '0;
                quo_d   = a_neg ? -a_i : a_i;
                dvs_d   = b_neg ? -b_i : b_i;
                a_d     = a_i;
                qneg_d  = a_neg ^ b_neg;
                rneg_d  = a_neg;
                dz_d    = (b_i == '0);
                remop_d = rem_i;
            end
            BUSY: begin
                // Shift one dividend bit into the partial remainder; keep the
                // subtraction only if it did not borrow.
                rem_d = diff[XLEN] ? {rem_q[XLEN-2:0], quo_q[XLEN-1]} : diff[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], ~diff[XLEN]};
                cnt_d = cnt_q + 1'b1;
                if (abort_i)
                    state_d = IDLE;
                else if (cnt_q == CW'(DIV_CYCLES - 1))
                    state_d = DONE;
            end
            DONE: if (abort_i || !hold_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            a_q     <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            remop_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            a_q     <= a_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            remop_q <= remop_d;
        end
    end

    // Most-negative / -1 falls out of the magnitude path: |q| = 2^(XLEN-1), no negation.
    assign result_o = dz_q    ? (remop_q ? a_q : '1) :
                      remop_q ? (rneg_q ? -rem_q : rem_q) :
                                (qneg_q ? -quo_q : quo_q);
    assign busy_o   = (state_q == BUSY) || ((state_q == IDLE) && start_i);
    assign done_o   = (state_q == DONE);

endmodule
`endif

// File: rtl/ex_stage.sv
// Execute stage: forwarding muxes, single-cycle ALU, optional iterative divider
// (EX_STAGE_DIV_EN) and the EX/MEM pipeline register.
module ex_stage import ex_pkg::*; #(
    parameter int XLEN       = 32,
    parameter int DIV_CYCLES = XLEN
) (
    input  logic     clk,
    input  logic     rst,
    ex_stage_if.slave bus
);

    logic [XLEN-1:0] op_a, rs2_fwd, op_b, alu_res, wr_res;
    logic            is_div, wr_en, div_busy;

    logic [XLEN-1:0] result_q, result_d, store_q, store_d;
    logic [4:0]      rd_q, rd_d;
    logic            valid_q, valid_d, rw_q, rw_d, mr_q, mr_d, mw_q, mw_d;

    function automatic logic [XLEN-1:0] fwd_mux(logic [1:0] sel, logic [XLEN-1:0] rf,
                                                logic [XLEN-1:0] mw, logic [XLEN-1:0] em);
        case (sel)
            FWD_REGFILE: return rf;
            FWD_MEMWB:   return mw;
            FWD_EXMEM:   return em;
            default:     return rf;
        endcase
    endfunction

    assign op_a    = fwd_mux(bus.forwardA, bus.id_ex_rs1_data, bus.mem_wb_fwd_data, bus.ex_mem_fwd_data);
    assign rs2_fwd = fwd_mux(bus.forwardB, bus.id_ex_rs2_data, bus.mem_wb_fwd_data, bus.ex_mem_fwd_data);
    assign op_b    = bus.id_ex_use_imm ? bus.id_ex_imm : rs2_fwd;
    assign is_div  = is_div_op(bus.id_ex_alu_op);

    always_comb begin
        alu_res = '0;
        case (bus.id_ex_alu_op)
            ALU_ADD:      alu_res = op_a + op_b;
            ALU_SUB:      alu_res = op_a - op_b;
            ALU_AND:      alu_res = op_a & op_b;
            ALU_OR:       alu_res = op_a | op_b;
            ALU_XOR:      alu_res = op_a ^ op_b;
            ALU_SLL:      alu_res = op_a << op_b[4:0];
            ALU_SRL:      alu_res = op_a >> op_b[4:0];
            ALU_SRA:      alu_res = $signed(op_a) >>> op_b[4:0];
            ALU_SLT:      alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_SLTU:     alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            ALU_LUI_PASS: alu_res = op_b;
            ALU_MUL:      alu_res = op_a * op_b;
            default:      alu_res = '0;
        endcase
    end

`ifdef EX_STAGE_DIV_EN
    logic            div_done;
    logic [XLEN-1:0] div_res;

    iter_divider #(.XLEN(XLEN), .DIV_CYCLES(DIV_CYCLES)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start_i  (bus.id_ex_valid & is_div & ~bus.flush),
        .abort_i  (bus.flush),
        .hold_i   (bus.mem_stall),
        .signed_i ((bus.id_ex_alu_op == ALU_DIV) || (bus.id_ex_alu_op == ALU_REM)),
        .rem_i    ((bus.id_ex_alu_op == ALU_REM) || (bus.id_ex_alu_op == ALU_REMU)),
        .a_i      (op_a),
        .b_i      (op_b),
        .busy_o   (div_busy),
        .done_o   (div_done),
        .result_o (div_res)
    );

    // A div op only reaches EX/MEM from DONE; until then it leaves bubbles behind.
    assign wr_en  = bus.id_ex_valid & ~bus.flush & (~is_div | div_done);
    assign wr_res = is_div ? div_res : alu_res;
`else
    assign div_busy = 1'b0;
    assign wr_en    = bus.id_ex_valid & ~bus.flush;
    assign wr_res   = alu_res;
`endif

    assign bus.ex_busy = bus.mem_stall | div_busy;

    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        store_d  = store_q;
        rd_d     = rd_q;
        rw_d     = rw_q;
        mr_d     = mr_q;
        mw_d     = mw_q;
        if (!bus.mem_stall) begin
            valid_d  = wr_en;
            result_d = wr_en ? wr_res : '0;
            store_d  = wr_en ? rs2_fwd : '0;
            rd_d     = wr_en ? bus.id_ex_rd : '0;
            rw_d     = wr_en & bus.id_ex_reg_write;
            mr_d     = wr_en & bus.id_ex_mem_read;
            mw_d     = wr_en & bus.id_ex_mem_write;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            store_q  <= '0;
            rd_q     <= '0;
            rw_q     <= 1'b0;
            mr_q     <= 1'b0;
            mw_q     <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            store_q  <= store_d;
            rd_q     <= rd_d;
            rw_q     <= rw_d;
            mr_q     <= mr_d;
            mw_q     <= mw_d;
        end
    end

    assign bus.ex_mem_valid      = valid_q;
    assign bus.ex_mem_result     = result_q;
    assign bus.ex_mem_store_data = store_q;
    assign bus.ex_mem_rd         = rd_q;
    assign bus.ex_mem_reg_write  = rw_q;
    assign bus.ex_mem_mem_read   = mr_q;
    assign bus.ex_mem_mem_write  = mw_q;

endmodule
